// File: rtl/zeroriscy_d_sram_pkg.sv
// Shared types and helpers for the zero-riscy data SRAM controller.
//   state_e        : controller FSM states
//   N_BANK/ROW_W   : SRAM geometry (8 banks x 4K rows x 32b)
//   bank_of/row_of : split a 15-bit word address into bank and row
//   lowest_onehot  : one-hot of the lowest set bit of a bank mask
package zeroriscy_d_sram_pkg;

    localparam int N_BANK  = 8;
    localparam int ROW_W   = 12;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = N_BANK * WORD_W;
    localparam int WADDR_W = 15;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACC_WR = 1'b1
    } state_e;

    function automatic logic [2:0] bank_of(input logic [WADDR_W-1:0] w);
        return 3'(w & WADDR_W'(N_BANK - 1));
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [WADDR_W-1:0] w);
        return ROW_W'(w >> 3);
    endfunction

    function automatic logic [N_BANK-1:0] lowest_onehot(input logic [N_BANK-1:0] m);
        return m & (~m + 1'b1);
    endfunction

endpackage

// File: rtl/zeroriscy_d_sram_ctrl_if.sv
// Requester-side bus of the data SRAM controller: the zero-riscy LSU word
// port (data_*) and the accelerator line port (acc_*).
//   master : the requesters (core LSU + accelerator)
//   slave  : the controller
interface zeroriscy_d_sram_ctrl_if;
    import zeroriscy_d_sram_pkg::*;

    logic                data_req;
    logic                data_gnt;
    logic                data_rvalid;
    logic [31:0]         data_addr;
    logic                data_we;
    logic [3:0]          data_be;
    logic [WORD_W-1:0]   data_wdata;
    logic [WORD_W-1:0]   data_rdata;

    logic                acc_req;
    logic                acc_we;
    logic [ROW_W-1:0]    acc_row;
    logic [N_BANK-1:0]   acc_wmask;
    logic [LINE_W-1:0]   acc_wdata;
    logic                acc_gnt;
    logic                acc_rvalid;
    logic [LINE_W-1:0]   acc_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        output acc_req, acc_we, acc_row, acc_wmask, acc_wdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  acc_gnt, acc_rvalid, acc_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        input  acc_req, acc_we, acc_row, acc_wmask, acc_wdata,
        output data_gnt, data_rvalid, data_rdata,
        output acc_gnt, acc_rvalid, acc_rdata
    );

endinterface

// File: rtl/zeroriscy_d_sram_rr_arb.sv
// Two-way arbiter between the core (req[0]) and the accelerator (req[1]).
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : requests
//   en        : arbitration allowed this cycle (grants forced low otherwise)
//   prio_core : 1 = core wins every conflict, 0 = round-robin
//   gnt[1:0]  : one-hot grant, combinational
module zeroriscy_d_sram_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       prio_core,
    output logic [1:0] gnt
);

    // Set when the accelerator was granted last, so the core wins the next tie.
    logic prefer_core_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || prio_core || prefer_core_q)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_core_q <= 1'b1;
        end else if (gnt[0]) begin
            prefer_core_q <= 1'b0;
        end else if (gnt[1]) begin
            prefer_core_q <= 1'b1;
        end
    end

endmodule

// File: rtl/zeroriscy_d_sram_ctrl.sv
// Arbiter/controller for the 8-bank x 4K x 32b byte-enabled data SRAM, shared
// between the zero-riscy LSU word port and an accelerator line port.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : core + accelerator requester bus (slave side)
//   sram_addr  : SRAM row
//   sram_cs    : per-bank chip selects
//   sram_we    : write strobe
//   sram_be    : byte enables
//   sram_din   : write data (same word to every selected bank)
//   sram_dout  : registered 256b read data, bank i at [32*(7-i)+:32]
//
// state  | meaning
// IDLE   | arbitrate; core ops and acc line reads issue in one cycle
// ACC_WR | acc masked line write, one bank per cycle lowest first; atomic
module zeroriscy_d_sram_ctrl #(
    parameter int ROW_W     = 12,
    parameter int N_BANK    = 8,
    parameter bit CORE_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    zeroriscy_d_sram_ctrl_if.slave bus,
    output logic [ROW_W-1:0]      sram_addr,
    output logic [N_BANK-1:0]     sram_cs,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [31:0]           sram_din,
    input  logic [N_BANK*32-1:0]  sram_dout
);
    import zeroriscy_d_sram_pkg::*;

    state_e               state_q, state_d;
    logic [N_BANK-1:0]    mask_q, mask_d;
    logic [ROW_W-1:0]     row_q;
    logic [N_BANK*32-1:0] wdata_q;
    logic [N_BANK-1:0]    burst_sel;

    logic [1:0]           arb_gnt;
    logic                 arb_en;
    logic                 core_go, acc_rd_go, acc_wr_go, burst_done;

    logic                 core_rvalid_q, core_rd_q;
    logic [2:0]           core_bank_q;
    logic                 acc_rvalid_q, acc_rd_q;

    // Only byte address bits [16:2] select a word; the rest alias.
    logic [WADDR_W-1:0]   waddr;
    logic                 unused_addr;
    assign waddr       = bus.data_addr[16:2];
    assign unused_addr = ^{bus.data_addr[31:17], bus.data_addr[1:0]};

    // Reset also blocks grants so nothing issues while it is held.
    assign arb_en = !rst && (state_q == IDLE);

    zeroriscy_d_sram_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({bus.acc_req, bus.data_req}),
        .en        (arb_en),
        .prio_core (CORE_PRIO),
        .gnt       (arb_gnt)
    );

    assign core_go   = arb_gnt[0];
    assign acc_rd_go = arb_gnt[1] && !bus.acc_we;
    assign acc_wr_go = arb_gnt[1] &&  bus.acc_we;

    assign bus.data_gnt = arb_gnt[0];
    assign bus.acc_gnt  = arb_gnt[1];

    assign burst_sel = lowest_onehot(mask_q);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        burst_done = 1'b0;
        sram_addr  = '0;
        sram_cs    = '0;
        sram_we    = 1'b0;
        sram_be    = 4'h0;
        sram_din   = '0;
        case (state_q)
            IDLE: begin
                if (core_go) begin
                    sram_addr                = row_of(waddr);
                    sram_cs[bank_of(waddr)]  = 1'b1;
                    sram_we                  = bus.data_we;
                    sram_be                  = bus.data_be;
                    sram_din                 = bus.data_wdata;
                end else if (acc_rd_go) begin
                    sram_addr = bus.acc_row;
                    sram_cs   = '1;
                end else if (acc_wr_go) begin
                    // Operands are latched this cycle; the first write is next cycle.
                    state_d = ACC_WR;
                end
            end
            ACC_WR: begin
                // A reset mid-burst must not let one more word slip out.
                if (!rst) begin
                    if (|mask_q) begin
                        sram_addr = row_q;
                        sram_cs   = burst_sel;
                        sram_we   = 1'b1;
                        sram_be   = 4'hF;
                        for (int i = 0; i < N_BANK; i++) begin
                            if (burst_sel[i]) begin
                                sram_din = wdata_q[32*(N_BANK-1-i) +: 32];
                            end
                        end
                    end
                    mask_d = mask_q & ~burst_sel;
                    if (mask_d == '0) begin
                        state_d    = IDLE;
                        burst_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            row_q         <= '0;
            wdata_q       <= '0;
            core_rvalid_q <= 1'b0;
            core_rd_q     <= 1'b0;
            core_bank_q   <= '0;
            acc_rvalid_q  <= 1'b0;
            acc_rd_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc_wr_go) begin
                mask_q  <= bus.acc_wmask;
                row_q   <= bus.acc_row;
                wdata_q <= bus.acc_wdata;
            end else begin
                mask_q <= mask_d;
            end
            core_rvalid_q <= core_go;
            core_rd_q     <= core_go && !bus.data_we;
            if (core_go) begin
                core_bank_q <= bank_of(waddr);
            end
            acc_rvalid_q <= acc_rd_go || burst_done;
            acc_rd_q     <= acc_rd_go;
        end
    end

    assign bus.data_rvalid = core_rvalid_q;
    assign bus.acc_rvalid  = acc_rvalid_q;
    assign bus.acc_rdata   = acc_rd_q ? sram_dout : '0;

    always_comb begin
        bus.data_rdata = '0;
        if (core_rvalid_q && core_rd_q) begin
            bus.data_rdata = sram_dout[32*(N_BANK-1-int'(core_bank_q)) +: 32];
        end
    end

endmodule

// File: tb/tb_zeroriscy_d_sram_ctrl.sv
module tb_zeroriscy_d_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zeroriscy_d_sram_ctrl_if bus ();
    zeroriscy_d_sram_ctrl_if bus2 ();

    logic [11:0]  sram_addr;
    logic [7:0]   sram_cs;
    logic         sram_we;
    logic [3:0]   sram_be;
    logic [31:0]  sram_din;
    logic [255:0] sram_dout;

    logic [11:0]  s2_addr;
    logic [7:0]   s2_cs;
    logic         s2_we;
    logic [3:0]   s2_be;
    logic [31:0]  s2_din;
    logic [255:0] s2_dout;
    assign s2_dout = '0;

    zeroriscy_d_sram_ctrl #(.CORE_PRIO(1'b0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_be   (sram_be),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    zeroriscy_d_sram_ctrl #(.CORE_PRIO(1'b1)) u_dut_prio (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .sram_addr (s2_addr),
        .sram_cs   (s2_cs),
        .sram_we   (s2_we),
        .sram_be   (s2_be),
        .sram_din  (s2_din),
        .sram_dout (s2_dout)
    );

    // Behavioural SRAM: 8 banks, byte-enabled writes, 1-cycle registered read.
    logic [31:0] mem [0:7][0:4095];
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (sram_cs[i]) begin
                if (sram_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sram_be[b]) mem[i][sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                    end
                end else begin
                    sram_dout[32*(7-i) +: 32] <= mem[i][sram_addr];
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] wr_log [0:15];

    task automatic core_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, output logic g, output logic [7:0] cs,
                           output logic [11:0] row, output logic rv, output logic [31:0] rd);
        bus.data_req = 1'b1; bus.data_addr = addr; bus.data_we = we;
        bus.data_be = be; bus.data_wdata = wd;
        #1;
        g = bus.data_gnt; cs = sram_cs; row = sram_addr;
        @(posedge clk); #1;
        bus.data_req = 1'b0; bus.data_we = 1'b0;
        rv = bus.data_rvalid; rd = bus.data_rdata;
    endtask

    task automatic acc_read(input logic [11:0] row, output logic g, output logic rv,
                            output logic dv, output logic [255:0] rd);
        bus.acc_req = 1'b1; bus.acc_we = 1'b0; bus.acc_row = row;
        #1;
        g = bus.acc_gnt;
        @(posedge clk); #1;
        bus.acc_req = 1'b0;
        rv = bus.acc_rvalid; dv = bus.data_rvalid; rd = bus.acc_rdata;
    endtask

    task automatic acc_write(input logic [11:0] row, input logic [7:0] mask,
                             input logic [255:0] data, output logic g, output int done_k);
        bus.acc_req = 1'b1; bus.acc_we = 1'b1; bus.acc_row = row;
        bus.acc_wmask = mask; bus.acc_wdata = data;
        #1;
        g = bus.acc_gnt;
        wr_log[0] = sram_we ? sram_cs : 8'h00;
        @(posedge clk); #1;
        bus.acc_req = 1'b0; bus.acc_we = 1'b0;
        done_k = 0;
        for (int k = 1; k < 16; k++) begin
            #1;
            wr_log[k] = sram_we ? sram_cs : 8'h00;
            if (bus.acc_rvalid && done_k == 0) done_k = k;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.data_gnt, bus.acc_gnt, bus.data_rvalid, bus.acc_rvalid} !== 4'b0) begin
            errors++; $display("FAIL reset_handshake: got %b exp 0000",
                {bus.data_gnt, bus.acc_gnt, bus.data_rvalid, bus.acc_rvalid});
        end
        checks++;
        if ({sram_cs, sram_we, sram_be, sram_din, sram_addr} !== 57'b0) begin
            errors++; $display("FAIL reset_sram: cs=%h we=%b be=%h din=%h addr=%h exp all 0",
                sram_cs, sram_we, sram_be, sram_din, sram_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.data_rvalid, bus.acc_rvalid, sram_cs, sram_we} !== 11'b0) begin
            errors++; $display("FAIL post_reset_idle: rv=%b/%b cs=%h we=%b exp 0",
                bus.data_rvalid, bus.acc_rvalid, sram_cs, sram_we);
        end
    endtask

    task automatic test_core_word();
        logic g, rv; logic [7:0] cs; logic [11:0] row; logic [31:0] rd;
        core_op(32'h0000_0014, 1'b1, 4'hF, 32'hDEAD_BEEF, g, cs, row, rv, rd);
        checks++;
        if ({g, cs, row, rv} !== {1'b1, 8'h20, 12'h000, 1'b1}) begin
            errors++; $display("FAIL core_write: gnt=%b cs=%h row=%h rvalid=%b exp 1 20 000 1",
                g, cs, row, rv);
        end
        core_op(32'h0000_0014, 1'b0, 4'hF, 32'h0, g, cs, row, rv, rd);
        checks++;
        if ({g, rv, rd} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL core_read: gnt=%b rvalid=%b rdata=%h exp 1 1 deadbeef", g, rv, rd);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.data_rvalid, sram_cs, sram_we} !== 10'b0) begin
            errors++; $display("FAIL idle_quiet: rvalid=%b cs=%h we=%b exp 0", bus.data_rvalid, sram_cs, sram_we);
        end
        core_op(32'h0002_0014, 1'b0, 4'hF, 32'h0, g, cs, row, rv, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL core_alias: rdata=%h exp deadbeef", rd);
        end
    endtask

    task automatic test_byte_enable();
        logic g, rv; logic [7:0] cs; logic [11:0] row; logic [31:0] rd;
        core_op(32'h0000_0040, 1'b1, 4'hF, 32'h1122_3344, g, cs, row, rv, rd);
        core_op(32'h0000_0040, 1'b1, 4'b0101, 32'hAABB_CCDD, g, cs, row, rv, rd);
        core_op(32'h0000_0040, 1'b0, 4'hF, 32'h0, g, cs, row, rv, rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL byte_enable: rdata=%h exp 11bb33dd", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic g1, g2, g3, g4, rv1, rv2; logic [7:0] cs; logic [11:0] row; logic [31:0] rd1, rd2;
        core_op(32'h0000_0200, 1'b1, 4'hF, 32'h0102_0304, g1, cs, row, rv1, rd1);
        core_op(32'h0000_0204, 1'b1, 4'hF, 32'h0506_0708, g2, cs, row, rv2, rd2);
        core_op(32'h0000_0200, 1'b0, 4'hF, 32'h0, g3, cs, row, rv1, rd1);
        core_op(32'h0000_0204, 1'b0, 4'hF, 32'h0, g4, cs, row, rv2, rd2);
        checks++;
        if ({g1, g2, g3, g4, rv1, rv2} !== 6'b111111) begin
            errors++; $display("FAIL b2b_handshake: gnts=%b%b%b%b rvalid=%b%b exp all 1", g1, g2, g3, g4, rv1, rv2);
        end
        checks++;
        if ({rd1, rd2} !== {32'h0102_0304, 32'h0506_0708}) begin
            errors++; $display("FAIL b2b_data: rdata=%h %h exp 01020304 05060708", rd1, rd2);
        end
    endtask

    task automatic test_acc_full_burst();
        logic g, rv, dv; logic [255:0] line, rd; int done_k;
        logic [7:0] cs; logic [11:0] row; logic [31:0] wrd;
        line = {32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007};
        acc_write(12'd3, 8'hFF, line, g, done_k);
        checks++;
        if ({g, wr_log[0]} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL full_grant: gnt=%b T-cycle cs=%h exp 1 00", g, wr_log[0]);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (wr_log[k] !== 8'(1 << (k - 1))) begin
                errors++; $display("FAIL full_write_T+%0d: cs=%h exp %h", k, wr_log[k], 8'(1 << (k - 1)));
            end
        end
        checks++;
        if (done_k !== 9) begin
            errors++; $display("FAIL full_rvalid: at T+%0d exp T+9", done_k);
        end
        acc_read(12'd3, g, rv, dv, rd);
        checks++;
        if ({g, rv, dv, rd} !== {1'b1, 1'b1, 1'b0, line}) begin
            errors++; $display("FAIL acc_read_line: gnt=%b rv=%b drv=%b rdata=%h", g, rv, dv, rd);
        end
        core_op(32'h0000_0060, 1'b0, 4'hF, 32'h0, g, cs, row, rv, wrd);
        checks++;
        if ({cs, row, wrd} !== {8'h01, 12'h003, 32'hA000_0000}) begin
            errors++; $display("FAIL core_read_line: cs=%h row=%h rdata=%h exp 01 003 a0000000", cs, row, wrd);
        end
        core_op(32'h0000_007C, 1'b0, 4'hF, 32'h0, g, cs, row, rv, wrd);
        checks++;
        if (wrd !== 32'hA000_0007) begin
            errors++; $display("FAIL core_read_bank7: rdata=%h exp a0000007", wrd);
        end
    endtask

    task automatic test_sparse_mask();
        logic g, rv; logic [255:0] line; int done_k;
        logic [7:0] cs; logic [11:0] row; logic [31:0] w0, w7; logic [7:0] extra;
        line = {32'hC0DE_0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'hC0DE_0007};
        acc_write(12'd7, 8'b1000_0001, line, g, done_k);
        extra = 8'h00;
        for (int k = 3; k < 16; k++) extra = extra | wr_log[k];
        checks++;
        if ({wr_log[1], wr_log[2], extra} !== {8'h01, 8'h80, 8'h00}) begin
            errors++; $display("FAIL sparse_writes: %h %h extra=%h exp 01 80 00", wr_log[1], wr_log[2], extra);
        end
        checks++;
        if (done_k !== 3) begin
            errors++; $display("FAIL sparse_rvalid: at T+%0d exp T+3", done_k);
        end
        core_op(32'h0000_00E0, 1'b0, 4'hF, 32'h0, g, cs, row, rv, w0);
        core_op(32'h0000_00FC, 1'b0, 4'hF, 32'h0, g, cs, row, rv, w7);
        checks++;
        if ({w0, w7} !== {32'hC0DE_0000, 32'hC0DE_0007}) begin
            errors++; $display("FAIL sparse_data: %h %h exp c0de0000 c0de0007", w0, w7);
        end
        acc_write(12'd9, 8'h00, line, g, done_k);
        extra = 8'h00;
        for (int k = 0; k < 16; k++) extra = extra | wr_log[k];
        checks++;
        if ({g, extra} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL zero_mask_writes: gnt=%b cs_or=%h exp 1 00", g, extra);
        end
        checks++;
        if (done_k !== 2) begin
            errors++; $display("FAIL zero_mask_rvalid: at T+%0d exp T+2", done_k);
        end
    endtask

    task automatic test_contention();
        logic g, rv, dv; logic [255:0] rd;
        logic [1:0] exp_g;
        int core_blocked;
        acc_read(12'd0, g, rv, dv, rd);
        bus.data_req = 1'b1; bus.data_addr = 32'h14; bus.data_we = 1'b0; bus.data_be = 4'hF;
        bus.acc_req = 1'b1; bus.acc_we = 1'b0; bus.acc_row = 12'd3;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({bus.acc_gnt, bus.data_gnt} !== exp_g) begin
                errors++; $display("FAIL rr_cycle%0d: gnt{acc,core}=%b exp %b", i, {bus.acc_gnt, bus.data_gnt}, exp_g);
            end
            if (i > 0) begin
                checks++;
                if ({bus.data_rvalid, bus.acc_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_rvalid%0d: {core,acc}=%b", i, {bus.data_rvalid, bus.acc_rvalid});
                end
            end
            @(posedge clk); #1;
        end
        bus.acc_we = 1'b1; bus.acc_wmask = 8'hFF;
        bus.acc_wdata = {32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                         32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007};
        #1;
        checks++;
        if ({bus.acc_gnt, bus.data_gnt} !== 2'b01) begin
            errors++; $display("FAIL rr_pre_burst: gnt{acc,core}=%b exp 01", {bus.acc_gnt, bus.data_gnt});
        end
        @(posedge clk); #1;
        #1;
        checks++;
        if ({bus.acc_gnt, bus.data_gnt} !== 2'b10) begin
            errors++; $display("FAIL rr_burst_grant: gnt{acc,core}=%b exp 10", {bus.acc_gnt, bus.data_gnt});
        end
        @(posedge clk); #1;
        bus.acc_req = 1'b0; bus.acc_we = 1'b0;
        core_blocked = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (!bus.data_gnt) core_blocked++;
            @(posedge clk); #1;
        end
        checks++;
        if (core_blocked !== 8) begin
            errors++; $display("FAIL burst_atomic: core blocked %0d of 8 burst cycles", core_blocked);
        end
        #1;
        checks++;
        if ({bus.data_gnt, bus.acc_rvalid, bus.data_rvalid} !== 3'b110) begin
            errors++; $display("FAIL burst_release: gnt=%b acc_rv=%b core_rv=%b exp 1 1 0",
                bus.data_gnt, bus.acc_rvalid, bus.data_rvalid);
        end
        @(posedge clk); #1;
        bus.data_req = 1'b0;
        checks++;
        if ({bus.data_rvalid, bus.acc_rvalid} !== 2'b10) begin
            errors++; $display("FAIL burst_core_resp: core_rv=%b acc_rv=%b exp 1 0", bus.data_rvalid, bus.acc_rvalid);
        end
    endtask

    task automatic test_core_prio();
        int core_wins, acc_wins;
        core_wins = 0; acc_wins = 0;
        bus2.data_req = 1'b1; bus2.data_addr = 32'h0; bus2.data_we = 1'b0; bus2.data_be = 4'hF;
        bus2.acc_req = 1'b1; bus2.acc_we = 1'b0; bus2.acc_row = 12'd1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus2.data_gnt) core_wins++;
            if (bus2.acc_gnt) acc_wins++;
            @(posedge clk); #1;
        end
        bus2.data_req = 1'b0; bus2.acc_req = 1'b0;
        checks++;
        if (core_wins !== 6 || acc_wins !== 0) begin
            errors++; $display("FAIL core_prio: core=%0d acc=%0d exp 6 0", core_wins, acc_wins);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic g, rv, dv; logic [255:0] oldl, newl, rd, expl; int done_k; int acc_pulses;
        logic [7:0] seen [1:3];
        oldl = {32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003,
                32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007};
        newl = {32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003,
                32'hC000_0004, 32'hC000_0005, 32'hC000_0006, 32'hC000_0007};
        expl = {newl[255:160], oldl[159:0]};
        acc_write(12'd5, 8'hFF, oldl, g, done_k);
        bus.acc_req = 1'b1; bus.acc_we = 1'b1; bus.acc_row = 12'd5;
        bus.acc_wmask = 8'hFF; bus.acc_wdata = newl;
        @(posedge clk); #1;
        bus.acc_req = 1'b0; bus.acc_we = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            seen[k] = sram_we ? sram_cs : 8'h00;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({seen[1], seen[2], seen[3]} !== 24'h010204) begin
            errors++; $display("FAIL rst_burst_pre: %h %h %h exp 01 02 04", seen[1], seen[2], seen[3]);
        end
        checks++;
        if ({sram_cs, sram_we, bus.acc_rvalid, bus.acc_gnt, bus.data_gnt} !== 12'b0) begin
            errors++; $display("FAIL rst_burst_outputs: cs=%h we=%b acc_rv=%b exp 0", sram_cs, sram_we, bus.acc_rvalid);
        end
        acc_pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.acc_rvalid) acc_pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (acc_pulses !== 0) begin
            errors++; $display("FAIL rst_burst_rvalid: %0d acc_rvalid pulses exp 0", acc_pulses);
        end
        acc_read(12'd5, g, rv, dv, rd);
        checks++;
        if (rd !== expl) begin
            errors++; $display("FAIL rst_burst_data: rdata=%h exp %h", rd, expl);
        end
    endtask

    initial begin
        bus.data_req = 1'b0; bus.data_addr = '0; bus.data_we = 1'b0; bus.data_be = '0; bus.data_wdata = '0;
        bus.acc_req = 1'b0; bus.acc_we = 1'b0; bus.acc_row = '0; bus.acc_wmask = '0; bus.acc_wdata = '0;
        bus2.data_req = 1'b0; bus2.data_addr = '0; bus2.data_we = 1'b0; bus2.data_be = '0; bus2.data_wdata = '0;
        bus2.acc_req = 1'b0; bus2.acc_we = 1'b0; bus2.acc_row = '0; bus2.acc_wmask = '0; bus2.acc_wdata = '0;
        test_reset();
        test_core_word();
        test_byte_enable();
        test_back_to_back();
        test_acc_full_burst();
        test_sparse_mask();
        test_contention();
        test_core_prio();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
